systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
Sequencer for the systolic array datapath: on a start pulse it runs one tile of matrix multiply.
- B preload
- Skewed A streaming, driving the per-row calculate enables
- Result drain to output memory
- Done pulse
It sits between the top-level host/memory interface and the datapath, and owns every datapath control input (cal_ele_cho_array, mem_ele_cho, mem_change) plus the A/B/C memory address and enable strobes.

Parameters:
systolic_size, 2, array dimension S (rows = columns = S); must be >= 1
addr_size, 8, width of memory addresses and of k_len

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to run one tile; sampled only in IDLE
k_len  input  addr_size  inner dimension K (number of A vectors); sampled with start
busy  output  1  high from the cycle after accepted start until the cycle done is asserted, inclusive
done  output  1  one-cycle pulse at tile completion
a_rd_en  output  1  A memory read strobe
a_rd_addr  output  addr_size  A memory read address
b_rd_en  output  1  B memory read strobe
b_rd_addr  output  addr_size  B memory read address
c_wr_en  output  1  result write strobe (results taken from datapath memory_out)
c_wr_addr  output  addr_size  result write address
cal_ele_cho_array  output  1 x [0:S-1] unpacked  per-row calculate enable into the datapath
mem_ele_cho  output  1  1 = PEs load B operand, 0 = PEs accumulate
mem_change  output  1  one-cycle pulse swapping datapath B operand buffer

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces state IDLE, all counters to 0, and every output to 0. This applies mid-operation as well: the tile is abandoned and no done pulse is produced.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE. Cycle n = n-th rising edge after the edge that samples start.
- IDLE:
  - start=1 with k_len!=0: latch k_len, go to LOAD.
  - start=1 with k_len==0: go to DONE directly; no memory strobes, no mem_change.
  - start is ignored in every other state.
- LOAD, cycles 1..S:
  - b_rd_en=1, b_rd_addr=0..S-1 incrementing, mem_ele_cho=1.
  - After S cycles go to COMPUTE.
- COMPUTE, K+S-1 cycles (K = latched k_len):
  - mem_change=1 in the first COMPUTE cycle only; mem_ele_cho=0 throughout.
  - Cycle c = 0..K+S-2 relative to COMPUTE entry:
    - a_rd_en=1, a_rd_addr=c, for c < K.
    - cal_ele_cho_array[r]=1 for r <= c <= r+K-1 (diagonal skew of one cycle per row).
  - Counter width addr_size+1, so K=2^addr_size-1 with S-1 extra cycles must not overflow.
- DRAIN, S cycles:
  - c_wr_en=1, c_wr_addr=0..S-1; cal_ele_cho_array all 0.
  - Then go to DONE.
- DONE, one cycle:
  - done=1, busy=1; then IDLE with busy=0.
  - A start arriving in the DONE cycle is ignored; the earliest acceptable start is the first IDLE cycle.
- Total occupancy for K>0: 3S+K-1 cycles plus the DONE cycle. For K=0: one DONE cycle.
- Address outputs hold their last value when the matching enable is 0. The bench must check addresses only while the enable is high.
- S=1 degenerate case: LOAD 1 cycle, COMPUTE K cycles, DRAIN 1 cycle. The skew rule still applies.

Test Plan:
- S=2, K=4, start pulse → cycles 1-2 b_rd_en addr 0,1 with mem_ele_cho=1; mem_change in cycle 3; a_rd_addr 0..3 in cycles 3-6; cal[0] high cycles 3-6, cal[1] high cycles 4-7; c_wr_addr 0,1 in cycles 8-9; done in cycle 10; busy high cycles 1-10.
- k_len=0 with start → done in cycle 1; no rd/wr strobes or mem_change ever asserted; busy high in cycle 1 only.
- Start held high continuously through a K=3, S=2 tile → exactly one tile per IDLE entry; second tile begins the cycle after the first-tile IDLE cycle; no start accepted mid-tile.
- Reset asserted asynchronously in the middle of COMPUTE (S=2, K=4, cycle 5) → all outputs 0 immediately without waiting for clk; no done pulse; next start runs a full correct tile.
- S=4, K=255, addr_size=8 → COMPUTE lasts 258 cycles with no counter wrap; cal[3] high exactly 255 cycles starting 3 cycles after cal[0]; done at cycle 3*4+255=267.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_if
//   Bundles every non-clock/reset signal of the systolic array sequencer.
//   The controller side uses the master modport; the host/datapath side
//   uses the slave modport.
//
//   Host request      : start, k_len                  (into the controller)
//   Host status       : busy, done                    (from the controller)
//   A memory read     : a_rd_en, a_rd_addr
//   B memory read     : b_rd_en, b_rd_addr
//   C memory write    : c_wr_en, c_wr_addr
//   Datapath control  : cal_ele_cho_array[0:S-1], mem_ele_cho, mem_change
// ---------------------------------------------------------------------------
interface systolic_ctrl_if #(
  parameter int systolic_size = 2,
  parameter int addr_size     = 8
);

  logic                 start;
  logic [addr_size-1:0] k_len;
  logic                 busy;
  logic                 done;
  logic                 a_rd_en;
  logic [addr_size-1:0] a_rd_addr;
  logic                 b_rd_en;
  logic [addr_size-1:0] b_rd_addr;
  logic                 c_wr_en;
  logic [addr_size-1:0] c_wr_addr;
  logic                 cal_ele_cho_array [0:systolic_size-1];
  logic                 mem_ele_cho;
  logic                 mem_change;

  modport master (
    input  start, k_len,
    output busy, done,
    output a_rd_en, a_rd_addr,
    output b_rd_en, b_rd_addr,
    output c_wr_en, c_wr_addr,
    output cal_ele_cho_array, mem_ele_cho, mem_change
  );

  modport slave (
    output start, k_len,
    input  busy, done,
    input  a_rd_en, a_rd_addr,
    input  b_rd_en, b_rd_addr,
    input  c_wr_en, c_wr_addr,
    input  cal_ele_cho_array, mem_ele_cho, mem_change
  );

endinterface

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
//   Sequencer for one tile of the systolic array matrix multiply:
//   B preload (LOAD), skewed A streaming with per-row calculate enables
//   (COMPUTE), result drain to output memory (DRAIN) and a done pulse (DONE).
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-low reset
//     bus    - systolic_ctrl_if.master: start/k_len request, busy/done
//              status, A/B/C memory strobes and datapath control
//
//   Timing: the state register runs one cycle ahead of the outputs. The edge
//   that samples start only moves the state; every output is then registered
//   from the current state, so the first LOAD strobe appears one edge later.
// ---------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int systolic_size = 2,
  parameter int addr_size     = 8
) (
  input  logic            clk,
  input  logic            reset,
  systolic_ctrl_if.master bus
);

  localparam int S  = systolic_size;
  localparam int AW = addr_size;
  // One spare bit so K = 2^AW-1 plus S-1 skew cycles never wraps.
  localparam int CW = addr_size + 1;

  localparam logic [CW-1:0] LAST_ROW = CW'(S - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    DONE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   kLen_q;

  logic            busy_q;
  logic            done_q;
  logic            aRdEn_q;
  logic [AW-1:0]   aRdAddr_q;
  logic            bRdEn_q;
  logic [AW-1:0]   bRdAddr_q;
  logic            cWrEn_q;
  logic [AW-1:0]   cWrAddr_q;
  logic            calEn_q [0:S-1];
  logic            memEleCho_q;
  logic            memChange_q;

  logic            calEn_d [0:S-1];
  logic [CW-1:0]   lastComputeCnt;
  logic [CW-1:0]   kWide;

  // COMPUTE spans K+S-1 cycles, so its final count is K+S-2. K is at least 1
  // whenever COMPUTE is entered, which keeps this non-negative even for S=1.
  always_comb begin
    kWide          = {1'b0, kLen_q};
    lastComputeCnt = kWide + CW'(S) - CW'(2);
  end

  // Diagonal skew: row r is active while the COMPUTE count lies in
  // [r, r+K-1]. The subtraction is guarded so it cannot underflow.
  always_comb begin
    for (int r = 0; r < S; r++) begin
      calEn_d[r] = 1'b0;
      if (state_q == COMPUTE && cnt_q >= CW'(r)) begin
        calEn_d[r] = ((cnt_q - CW'(r)) < kWide);
      end
    end
  end

  // Single sequencing process: state transitions plus every registered
  // output. Strobes default low each cycle; addresses only move while their
  // enable is being asserted, so they hold their last value otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kLen_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aRdEn_q     <= 1'b0;
      aRdAddr_q   <= '0;
      bRdEn_q     <= 1'b0;
      bRdAddr_q   <= '0;
      cWrEn_q     <= 1'b0;
      cWrAddr_q   <= '0;
      calEn_q     <= '{default: 1'b0};
      memEleCho_q <= 1'b0;
      memChange_q <= 1'b0;
    end else begin
      busy_q      <= (state_q != IDLE);
      done_q      <= 1'b0;
      aRdEn_q     <= 1'b0;
      bRdEn_q     <= 1'b0;
      cWrEn_q     <= 1'b0;
      memEleCho_q <= 1'b0;
      memChange_q <= 1'b0;
      calEn_q     <= calEn_d;

      case (state_q)
        IDLE: begin
          // done_q high means the visible DONE cycle is still in progress;
          // a start seen then is ignored.
          if (bus.start && !done_q) begin
            cnt_q <= '0;
            if (bus.k_len == '0) begin
              state_q <= DONE;
            end else begin
              kLen_q  <= bus.k_len;
              state_q <= LOAD;
            end
          end
        end

        LOAD: begin
          bRdEn_q     <= 1'b1;
          bRdAddr_q   <= cnt_q[AW-1:0];
          memEleCho_q <= 1'b1;
          if (cnt_q == LAST_ROW) begin
            cnt_q   <= '0;
            state_q <= COMPUTE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        COMPUTE: begin
          memChange_q <= (cnt_q == '0);
          if (cnt_q < kWide) begin
            aRdEn_q   <= 1'b1;
            aRdAddr_q <= cnt_q[AW-1:0];
          end
          if (cnt_q == lastComputeCnt) begin
            cnt_q   <= '0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DRAIN: begin
          cWrEn_q   <= 1'b1;
          cWrAddr_q <= cnt_q[AW-1:0];
          if (cnt_q == LAST_ROW) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.a_rd_en           = aRdEn_q;
  assign bus.a_rd_addr         = aRdAddr_q;
  assign bus.b_rd_en           = bRdEn_q;
  assign bus.b_rd_addr         = bRdAddr_q;
  assign bus.c_wr_en           = cWrEn_q;
  assign bus.c_wr_addr         = cWrAddr_q;
  assign bus.cal_ele_cho_array = calEn_q;
  assign bus.mem_ele_cho       = memEleCho_q;
  assign bus.mem_change        = memChange_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl
//   Drives two sequencer instances (S=2 and S=4, addr_size=8). For every tile
//   the expected output vector of each cycle is derived from the tile timing
//   (LOAD 1..S, COMPUTE S+1..2S+K-1, DRAIN 2S+K..3S+K-1, DONE 3S+K) and
//   queued when start is driven; a negedge monitor per instance pops one
//   entry per cycle and compares, expecting all-idle outputs when empty.
// ---------------------------------------------------------------------------
module tb_systolic_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       aEn;
    logic [7:0] aAddr;
    logic       bEn;
    logic [7:0] bAddr;
    logic       cEn;
    logic [7:0] cAddr;
    logic [7:0] cal;
    logic       mec;
    logic       mch;
  } outVec_t;

  logic clk;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;
  int cal3Count   = 0;

  outVec_t q2[$];
  outVec_t q4[$];
  outVec_t act2, exp2, act4, exp4, rstAct;

  systolic_ctrl_if #(.systolic_size(2), .addr_size(8)) bus2 ();
  systolic_ctrl_if #(.systolic_size(4), .addr_size(8)) bus4 ();

  systolic_ctrl #(.systolic_size(2), .addr_size(8)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  systolic_ctrl #(.systolic_size(4), .addr_size(8)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s @%0t: observed %0h expected %0h",
               tag, $time, actual, expected);
    end
  endtask

  // Field-by-field comparison; addresses only matter while enabled.
  task automatic compareVecs(input string tag, input outVec_t act, input outVec_t exp);
    checkOutput({tag, ".busy"}, 32'(act.busy), 32'(exp.busy));
    checkOutput({tag, ".done"}, 32'(act.done), 32'(exp.done));
    checkOutput({tag, ".aEn"},  32'(act.aEn),  32'(exp.aEn));
    checkOutput({tag, ".bEn"},  32'(act.bEn),  32'(exp.bEn));
    checkOutput({tag, ".cEn"},  32'(act.cEn),  32'(exp.cEn));
    checkOutput({tag, ".cal"},  32'(act.cal),  32'(exp.cal));
    checkOutput({tag, ".mec"},  32'(act.mec),  32'(exp.mec));
    checkOutput({tag, ".mch"},  32'(act.mch),  32'(exp.mch));
    if (exp.aEn) checkOutput({tag, ".aAddr"}, 32'(act.aAddr), 32'(exp.aAddr));
    if (exp.bEn) checkOutput({tag, ".bAddr"}, 32'(act.bAddr), 32'(exp.bAddr));
    if (exp.cEn) checkOutput({tag, ".cAddr"}, 32'(act.cAddr), 32'(exp.cAddr));
  endtask

  // Expected outputs in cycle n (n-th edge after the start-sampling edge).
  function automatic outVec_t expVec(input int s, input int k, input int n);
    outVec_t v;
    int c;
    int d;
    int nDone;
    v = '0;
    if (n < 1) return v;
    if (k == 0) begin
      if (n == 1) begin
        v.busy = 1'b1;
        v.done = 1'b1;
      end
      return v;
    end
    nDone = 3 * s + k;
    if (n > nDone) return v;
    v.busy = 1'b1;
    if (n <= s) begin
      v.bEn   = 1'b1;
      v.bAddr = 8'(n - 1);
      v.mec   = 1'b1;
    end else if (n <= 2 * s + k - 1) begin
      c     = n - s - 1;
      v.mch = (c == 0);
      if (c < k) begin
        v.aEn   = 1'b1;
        v.aAddr = 8'(c);
      end
      for (int r = 0; r < s; r++) begin
        if (c >= r && c <= r + k - 1) v.cal[r] = 1'b1;
      end
    end else if (n < nDone) begin
      d       = n - (2 * s + k);
      v.cEn   = 1'b1;
      v.cAddr = 8'(d);
    end else begin
      v.done = 1'b1;
    end
    return v;
  endfunction

  function automatic outVec_t sample2();
    outVec_t v;
    v       = '0;
    v.busy  = bus2.busy;
    v.done  = bus2.done;
    v.aEn   = bus2.a_rd_en;
    v.aAddr = bus2.a_rd_addr;
    v.bEn   = bus2.b_rd_en;
    v.bAddr = bus2.b_rd_addr;
    v.cEn   = bus2.c_wr_en;
    v.cAddr = bus2.c_wr_addr;
    v.mec   = bus2.mem_ele_cho;
    v.mch   = bus2.mem_change;
    for (int r = 0; r < 2; r++) v.cal[r] = bus2.cal_ele_cho_array[r];
    return v;
  endfunction

  function automatic outVec_t sample4();
    outVec_t v;
    v       = '0;
    v.busy  = bus4.busy;
    v.done  = bus4.done;
    v.aEn   = bus4.a_rd_en;
    v.aAddr = bus4.a_rd_addr;
    v.bEn   = bus4.b_rd_en;
    v.bAddr = bus4.b_rd_addr;
    v.cEn   = bus4.c_wr_en;
    v.cAddr = bus4.c_wr_addr;
    v.mec   = bus4.mem_ele_cho;
    v.mch   = bus4.mem_change;
    for (int r = 0; r < 4; r++) v.cal[r] = bus4.cal_ele_cho_array[r];
    return v;
  endfunction

  // Scoreboard monitors: one expected vector popped per cycle, idle if empty.
  always @(negedge clk) begin
    act2 = sample2();
    exp2 = (q2.size() > 0) ? q2.pop_front() : '0;
    compareVecs("s2", act2, exp2);
  end

  always @(negedge clk) begin
    act4 = sample4();
    exp4 = (q4.size() > 0) ? q4.pop_front() : '0;
    compareVecs("s4", act4, exp4);
    if (bus4.cal_ele_cho_array[3]) cal3Count++;
  end

  task automatic pushTile(input int sel, input int k);
    int last;
    last = (k == 0) ? 1 : 3 * sel + k;
    for (int n = 0; n <= last; n++) begin
      if (sel == 2) q2.push_back(expVec(2, k, n));
      else          q4.push_back(expVec(4, k, n));
    end
  endtask

  // Waits for the scoreboard of one instance to empty, with a cycle bound.
  task automatic waitDrain(input int sel, input int budget);
    int left;
    left = (sel == 2) ? q2.size() : q4.size();
    for (int i = 0; i < budget && left > 0; i++) begin
      @(negedge clk);
      left = (sel == 2) ? q2.size() : q4.size();
    end
    checkOutput("drain", 32'(left), 32'd0);
  endtask

  // One start pulse for one tile, expectations queued alongside.
  task automatic applyStimulus(input int sel, input int k);
    @(negedge clk);
    #1;
    pushTile(sel, k);
    if (sel == 2) begin
      bus2.start = 1'b1;
      bus2.k_len = 8'(k);
    end else begin
      bus4.start = 1'b1;
      bus4.k_len = 8'(k);
    end
    @(negedge clk);
    #1;
    bus2.start = 1'b0;
    bus4.start = 1'b0;
    waitDrain(sel, 3 * sel + k + 20);
  endtask

  initial begin
    reset      = 1'b0;
    bus2.start = 1'b0;
    bus2.k_len = '0;
    bus4.start = 1'b0;
    bus4.k_len = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic tiles, including the empty tile and a single A vector.
    applyStimulus(2, 4);
    applyStimulus(2, 0);
    applyStimulus(2, 1);
    applyStimulus(4, 2);

    // Start held high: one tile per IDLE entry, second accepted after the
    // DONE cycle plus one IDLE cycle.
    @(negedge clk);
    #1;
    for (int n = 0; n <= 9; n++) q2.push_back(expVec(2, 3, n));
    q2.push_back('0);
    for (int n = 0; n <= 9; n++) q2.push_back(expVec(2, 3, n));
    bus2.start = 1'b1;
    bus2.k_len = 8'd3;
    repeat (12) @(negedge clk);
    #1 bus2.start = 1'b0;
    waitDrain(2, 40);

    // Asynchronous reset in cycle 5 (COMPUTE) of an S=2, K=4 tile.
    @(negedge clk);
    #1;
    pushTile(2, 4);
    bus2.start = 1'b1;
    bus2.k_len = 8'd4;
    @(negedge clk);
    #1 bus2.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;
    q2.delete();
    #1;
    rstAct = sample2();
    compareVecs("rst", rstAct, '0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    applyStimulus(2, 4);

    // Full-width K on the S=4 instance: 258 COMPUTE cycles, done at 267.
    cal3Count = 0;
    applyStimulus(4, 255);
    checkOutput("cal3cnt", 32'(cal3Count), 32'd255);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
